// File: rtl/serial_tx8.sv
// Framed serial transmitter: accepts a parallel word on valid/ready and shifts it out
// as start bit, data LSB first, optional even parity, stop bit. All outputs registered.
//
// state  | meaning
// IDLE   | line high, load_ready=1, waiting for load_valid
// START  | start bit (low) for CLKS_PER_BIT cycles
// DATA   | data bits LSB first, one per CLKS_PER_BIT cycles
// PARITY | even-parity bit of the latched word (only when PARITY_EN=1)
// STOP   | stop bit (high); done pulses in the following IDLE cycle
module serial_tx8 #(
    parameter int DATA_W       = 8,
    parameter int CLKS_PER_BIT = 4,
    parameter int PARITY_EN    = 0
) (
    input  logic              Clk,
    input  logic              reset,
    input  logic [DATA_W-1:0] P,
    input  logic              load_valid,
    output logic              load_ready,
    output logic              tx_out,
    output logic              busy,
    output logic              done
);

    localparam int BW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam logic [BW-1:0] BAUD_LAST = BW'(CLKS_PER_BIT - 1);
    localparam logic [4:0]    BIT_LAST  = 5'(DATA_W - 1);

    typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;

    state_t            state, state_nxt;
    logic [DATA_W-1:0] shift, shift_nxt;
    logic              par, par_nxt;
    logic [4:0]        bit_cnt, bit_nxt;
    logic [BW-1:0]     baud_cnt, baud_nxt;
    logic              baud_last;
    logic              tx_nxt, done_nxt;

    always_ff @(posedge Clk or negedge reset) begin
        if (!reset) begin
            state      <= IDLE;
            shift      <= '0;
            par        <= 1'b0;
            bit_cnt    <= '0;
            baud_cnt   <= '0;
            tx_out     <= 1'b1;
            done       <= 1'b0;
            busy       <= 1'b0;
            load_ready <= 1'b1;
        end else begin
            state      <= state_nxt;
            shift      <= shift_nxt;
            par        <= par_nxt;
            bit_cnt    <= bit_nxt;
            baud_cnt   <= baud_nxt;
            tx_out     <= tx_nxt;
            done       <= done_nxt;
            busy       <= (state_nxt != IDLE);
            load_ready <= (state_nxt == IDLE);
        end
    end

    always_comb begin
        state_nxt = state;
        shift_nxt = shift;
        par_nxt   = par;
        bit_nxt   = bit_cnt;
        baud_nxt  = baud_cnt;
        done_nxt  = 1'b0;
        baud_last = (baud_cnt == BAUD_LAST);

        if (state != IDLE)
            baud_nxt = baud_last ? '0 : baud_cnt + 1'b1;

        case (state)
            IDLE: begin
                if (load_valid && load_ready) begin
                    state_nxt = START;
                    shift_nxt = P;
                    par_nxt   = ^P;
                    baud_nxt  = '0;
                    bit_nxt   = '0;
                end
            end
            START: begin
                if (baud_last)
                    state_nxt = DATA;
            end
            DATA: begin
                if (baud_last) begin
                    shift_nxt = shift >> 1;
                    if (bit_cnt == BIT_LAST) begin
                        bit_nxt   = '0;
                        state_nxt = (PARITY_EN != 0) ? PARITY : STOP;
                    end else begin
                        bit_nxt = bit_cnt + 1'b1;
                    end
                end
            end
            PARITY: begin
                if (baud_last)
                    state_nxt = STOP;
            end
            STOP: begin
                if (baud_last) begin
                    state_nxt = IDLE;
                    done_nxt  = 1'b1;
                end
            end
            default: state_nxt = IDLE;
        endcase

        // The line level is registered, so it follows the state being entered.
        case (state_nxt)
            START:   tx_nxt = 1'b0;
            DATA:    tx_nxt = shift_nxt[0];
            PARITY:  tx_nxt = par_nxt;
            default: tx_nxt = 1'b1;
        endcase
    end

endmodule

// File: tb/tb_serial_tx8.sv
// Bench for serial_tx8: instance a uses the defaults (8 bits, 4 clks/bit, no parity),
// instance b uses 1 clk/bit with even parity. Frames are predicted from the word alone.
module tb_serial_tx8;

    logic       Clk = 1'b0;
    logic       reset = 1'b0;
    logic [7:0] p_a = 8'h00, p_b = 8'h00;
    logic       lv_a = 1'b0, lv_b = 1'b0;
    logic       rdy_a, tx_a, busy_a, done_a;
    logic       rdy_b, tx_b, busy_b, done_b;

    int total = 0;
    int bad   = 0;

    always #5 Clk = ~Clk;

    serial_tx8 #(.DATA_W(8), .CLKS_PER_BIT(4), .PARITY_EN(0)) dut_a (
        .Clk(Clk), .reset(reset), .P(p_a), .load_valid(lv_a),
        .load_ready(rdy_a), .tx_out(tx_a), .busy(busy_a), .done(done_a)
    );

    serial_tx8 #(.DATA_W(8), .CLKS_PER_BIT(1), .PARITY_EN(1)) dut_b (
        .Clk(Clk), .reset(reset), .P(p_b), .load_valid(lv_b),
        .load_ready(rdy_b), .tx_out(tx_b), .busy(busy_b), .done(done_b)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic tx_of(input int sel);   return (sel != 0) ? tx_b   : tx_a;   endfunction
    function automatic logic rdy_of(input int sel);  return (sel != 0) ? rdy_b  : rdy_a;  endfunction
    function automatic logic busy_of(input int sel); return (sel != 0) ? busy_b : busy_a; endfunction
    function automatic logic done_of(input int sel); return (sel != 0) ? done_b : done_a; endfunction

    function automatic int cpb_of(input int sel);
        return (sel != 0) ? 1 : 4;
    endfunction

    function automatic int frame_len(input int sel);
        return (8 + 2 + sel) * cpb_of(sel);
    endfunction

    // Reference: which bit of the frame is on the line during cycle i after the accept edge.
    function automatic logic exp_bit(input int sel, input logic [7:0] w, input int i);
        int idx;
        idx = i / cpb_of(sel);
        if (idx == 0) return 1'b0;
        if (idx <= 8) return w[idx-1];
        if (sel != 0 && idx == 9) return ^w;
        return 1'b1;
    endfunction

    task automatic set_in(input int sel, input logic [7:0] p, input logic lv);
        if (sel != 0) begin p_b = p; lv_b = lv; end
        else begin p_a = p; lv_a = lv; end
    endtask

    // Called at a falling edge; returns when the next rising edge will accept the word.
    task automatic start(input int sel, input logic [7:0] w);
        set_in(sel, w, 1'b1);
        for (int n = 0; n < 400 && !rdy_of(sel); n++) @(negedge Clk);
        check("accept_ready", rdy_of(sel), 1);
    endtask

    // Checks every cycle of one frame, then the done cycle.
    task automatic check_frame(input int sel, input logic [7:0] w, input logic [7:0] p0,
                               input logic lv0, input int inj, input logic [7:0] pinj);
        for (int i = 0; i < frame_len(sel); i++) begin
            @(negedge Clk);
            if (i == 0) set_in(sel, p0, lv0);
            if (i == inj) set_in(sel, pinj, 1'b1);
            check($sformatf("tx[%0d] w=%0h", i, w), tx_of(sel), exp_bit(sel, w, i));
            check("busy_in_frame", busy_of(sel), 1);
            check("ready_in_frame", rdy_of(sel), 0);
            check("done_in_frame", done_of(sel), 0);
        end
        @(negedge Clk);
        check("done_pulse", done_of(sel), 1);
        check("busy_after", busy_of(sel), 0);
        check("ready_after", rdy_of(sel), 1);
        check("tx_idle_gap", tx_of(sel), 1);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog expired");
        $fatal(1, "timeout");
    end

    initial begin
        int sel, gap;
        logic [7:0] w;

        // reset held with load_valid asserted
        lv_a = 1'b1;
        lv_b = 1'b1;
        repeat (3) begin
            @(negedge Clk);
            check("rst_tx", tx_a, 1);
            check("rst_ready", rdy_a, 1);
            check("rst_busy", busy_a, 0);
            check("rst_done", done_a, 0);
            check("rst_b_tx", tx_b, 1);
        end
        lv_a = 1'b0;
        lv_b = 1'b0;
        reset = 1'b1;
        @(negedge Clk);
        check("post_rst_busy", busy_a, 0);
        check("post_rst_tx", tx_a, 1);

        // single frame A5
        start(0, 8'hA5);
        check_frame(0, 8'hA5, 8'hA5, 1'b0, -1, 8'h00);
        @(negedge Clk);
        check("done_one_cycle", done_a, 0);

        // parity frames
        start(1, 8'h07);
        check_frame(1, 8'h07, 8'h07, 1'b0, -1, 8'h00);
        @(negedge Clk);
        check("b_done_one_cycle", done_b, 0);
        start(1, 8'h03);
        check_frame(1, 8'h03, 8'h03, 1'b0, -1, 8'h00);
        @(negedge Clk);

        // back-to-back with load_valid held, P changed during frame 1
        start(0, 8'h00);
        check_frame(0, 8'h00, 8'hFF, 1'b1, -1, 8'h00);
        check_frame(0, 8'hFF, 8'hFF, 1'b0, -1, 8'h00);
        @(negedge Clk);

        // load attempt while busy is held off until done
        start(0, 8'h5A);
        check_frame(0, 8'h5A, 8'h5A, 1'b0, 10, 8'h3C);
        check_frame(0, 8'h3C, 8'h3C, 1'b0, -1, 8'h00);
        @(negedge Clk);

        // reset during data bit 3
        start(0, 8'hC6);
        for (int i = 0; i < 18; i++) begin
            @(negedge Clk);
            if (i == 0) set_in(0, 8'hC6, 1'b0);
            check($sformatf("pre_abort_tx[%0d]", i), tx_a, exp_bit(0, 8'hC6, i));
        end
        reset = 1'b0;
        #1;
        check("abort_tx", tx_a, 1);
        check("abort_busy", busy_a, 0);
        check("abort_ready", rdy_a, 1);
        check("abort_done", done_a, 0);
        repeat (2) begin
            @(negedge Clk);
            check("abort_no_done", done_a, 0);
        end
        reset = 1'b1;
        @(negedge Clk);
        check("after_abort_done", done_a, 0);
        check("after_abort_busy", busy_a, 0);
        start(0, 8'h81);
        check_frame(0, 8'h81, 8'h81, 1'b0, -1, 8'h00);
        @(negedge Clk);

        // random words on both instances with random idle gaps
        repeat (12) begin
            sel = int'($urandom_range(0, 1));
            w   = 8'($urandom);
            gap = int'($urandom_range(0, 3));
            start(sel, w);
            check_frame(sel, w, w, 1'b0, -1, 8'h00);
            @(negedge Clk);
            check("rand_done_low", done_of(sel), 0);
            repeat (gap) @(negedge Clk);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/serial_tx8.md
Name: serial_tx8

Overview:
- Parallel-in, serial-out transmitter: the counterpart of the 8-bit parallel register.
- Captures a DATA_W-bit word from a parallel bus on a valid/ready handshake.
- Shifts the word out on a single line as a framed bit stream: start bit, data LSB first, optional even parity, stop bit.
- Sits downstream of the lab register block and drives the board serial/LED line.

Parameters:
DATA_W, 8, number of data bits per frame (1..16).
CLKS_PER_BIT, 4, Clk cycles each bit is held on tx_out (>=1).
PARITY_EN, 0, 1 = insert an even-parity bit between the data bits and the stop bit.

Ports:
Clk  input  1  system clock; all state updates on the rising edge.
reset  input  1  asynchronous, active-low reset.
P  input  DATA_W  parallel data word to transmit.
load_valid  input  1  P is valid and requests transmission.
load_ready  output  1  transmitter can accept a word this cycle.
tx_out  output  1  serial line; idles high.
busy  output  1  frame in progress (any state other than IDLE).
done  output  1  one-cycle pulse when a frame completes.

Behaviour:
- Reset (reset=0, asynchronous, takes effect immediately):
  - state=IDLE, tx_out=1, load_ready=1, busy=0, done=0.
  - Shift register, bit counter and baud counter cleared.
- All outputs are registered. load_ready = (state==IDLE) and is registered with state.
- States: IDLE -> START -> DATA -> [PARITY if PARITY_EN] -> STOP -> IDLE.
- IDLE: tx_out=1. On an edge with load_valid=1 and load_ready=1 (accept):
  - P latched into the shift register; parity = XOR of P latched.
  - state<=START, baud counter<=0.
  - P changes after the accept edge have no effect on the frame in progress.
- START: tx_out=0 for CLKS_PER_BIT cycles.
- DATA: tx_out = shift[0]. After each CLKS_PER_BIT cycles: shift right by one, bit counter +1. After DATA_W bits, go to PARITY or STOP.
- PARITY: tx_out = XOR of the latched data (even parity) for CLKS_PER_BIT cycles.
- STOP: tx_out=1 for CLKS_PER_BIT cycles, then state<=IDLE and done<=1 for exactly one cycle (the first IDLE cycle).
- Baud counter: counts 0..CLKS_PER_BIT-1 and wraps to 0 on each bit boundary. With CLKS_PER_BIT=1, the state and bit advance every cycle.
- Frame length: (DATA_W+2+PARITY_EN)*CLKS_PER_BIT cycles, from the edge after accept to the return to IDLE.
- Back-to-back frames:
  - load_valid held high is accepted in the first IDLE cycle, the same cycle done=1.
  - Minimum gap between consecutive frames is one idle-high cycle.
- load_valid while busy: ignored, since load_ready=0. Upstream must hold load_valid until it is accepted.
- Reset mid-frame: the frame is aborted, tx_out returns to 1 immediately and no done pulse is produced. After reset deasserts, the first edge behaves as IDLE.
- busy=1 exactly when state != IDLE. busy and load_ready are always complementary.

Test Plan:
- Reset: hold reset=0 for 3 cycles with load_valid=1 -> tx_out=1, load_ready=1, busy=0, done=0 throughout, and no frame starts.
- Single frame: defaults, P=8'hA5, load_valid pulsed for 1 cycle -> tx_out holds each of 0,1,0,1,0,0,1,0,1,1 for 4 cycles (40 cycles total); done=1 for one cycle immediately after; busy high for exactly 40 cycles.
- Parity: PARITY_EN=1, CLKS_PER_BIT=1, P=8'h07 -> tx_out = 0,1,1,1,0,0,0,0,0,1,1 (parity=1), 11 cycles; then P=8'h03 -> parity bit=0.
- Back-to-back: load_valid held high with P=8'h00 then 8'hFF -> second start bit begins exactly 1 idle-high cycle after the first stop bit; P change during frame 1 does not corrupt frame 1.
- Ignored load: assert load_valid with P=8'h3C mid-frame -> load_ready=0 and frame unchanged; 8'h3C is sent only after done.
- Reset mid-frame: assert reset=0 during data bit 3 -> tx_out=1 same cycle, busy=0, no done; a new P=8'h81 after release transmits correctly.
